pulse_meas: RTL and testbench

PULSE_MEAS -- requirements
Module: pulse_meas

---
 rtl/pulse_meas.sv | 105 ++++++++++
 tb/tb_pulse_meas.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_meas.sv
// rtl/pulse_meas.sv - measures delay from arming to a pin rising edge and the width of the following pulse
module pulse_meas #(
    parameter int width = 16,
    parameter int sync  = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic             pin,
    output logic             busy,
    output logic             valid,
    output logic [width-1:0] dly,
    output logic [width-1:0] len,
    output logic             ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        HIGH = 2'd2
    } state_t;

    localparam logic [width-1:0] CNT_MAX = '1;
    localparam logic [width-1:0] CNT_ONE = {{(width-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [sync-1:0]  r_sync;
    logic             r_ps_d;
    logic [width-1:0] r_cnt;

    logic             w_ps;
    logic             w_rise;
    logic             w_cnt_sat;
    logic [width-1:0] w_cnt_inc;

    assign w_ps      = r_sync[sync-1];
    assign w_rise    = w_ps & ~r_ps_d;
    assign w_cnt_sat = (r_cnt == CNT_MAX);
    // A saturated counter holds its value; ovf records the lost increment.
    assign w_cnt_inc = w_cnt_sat ? r_cnt : r_cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_sync <= '0;
            r_ps_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[sync-2:0], pin};
            r_ps_d <= w_ps;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            dly     <= '0;
            len     <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state <= ARM;
                        busy    <= 1'b1;
                        r_cnt   <= '0;
                        valid   <= 1'b0;
                        ovf     <= 1'b0;
                    end
                end
                ARM: begin
                    if (w_rise) begin
                        dly     <= r_cnt;
                        r_cnt   <= CNT_ONE;
                        r_state <= HIGH;
                    end else begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_sat) begin
                            ovf <= 1'b1;
                        end
                    end
                end
                HIGH: begin
                    if (w_ps) begin
                        r_cnt <= w_cnt_inc;
                        if (w_cnt_sat) begin
                            ovf <= 1'b1;
                        end
                    end else begin
                        len     <= r_cnt;
                        valid   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_meas.sv
// tb/tb_pulse_meas.sv - randomized and directed bench for pulse_meas against a waveform-scanning reference
module tb_pulse_meas;

    localparam int NMAX = 512;
    localparam int W0 = 16;
    localparam int S0 = 2;
    localparam int W1 = 4;
    localparam int S1 = 3;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic start = 1'b0;
    logic pin = 1'b0;

    logic          busy0, valid0, ovf0;
    logic [W0-1:0] dly0, len0;
    logic          busy1, valid1, ovf1;
    logic [W1-1:0] dly1, len1;

    pulse_meas #(.width(W0), .sync(S0)) u_dut0 (
        .clk(clk), .rstn(rstn), .start(start), .pin(pin),
        .busy(busy0), .valid(valid0), .dly(dly0), .len(len0), .ovf(ovf0)
    );

    pulse_meas #(.width(W1), .sync(S1)) u_dut1 (
        .clk(clk), .rstn(rstn), .start(start), .pin(pin),
        .busy(busy1), .valid(valid1), .dly(dly1), .len(len1), .ovf(ovf1)
    );

    always #5 clk = ~clk;

    // Stimulus value sampled at edge e lives at index e.
    bit in_rstn[NMAX];
    bit in_start[NMAX];
    bit in_pin[NMAX];

    int ex_busy[2][NMAX];
    int ex_valid[2][NMAX];
    int ex_dly[2][NMAX];
    int ex_len[2][NMAX];
    int ex_ovf[2][NMAX];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat(input int x, input int mx);
        return (x > mx) ? mx : x;
    endfunction

    // Synchronized pin level in the cycle after edge e, given last reset edge r.
    function automatic int ps_at(input int e, input int r, input int sy);
        int i;
        i = e - sy + 1;
        if (i <= r || i < 0 || i >= NMAX) return 0;
        return int'(in_pin[i]);
    endfunction

    task automatic compute(input int k, input int mx, input int sy, input int n);
        int st, s, m, f, oe, r, a, b;
        int bz, vl, dl, ln, ov;
        st = 0; s = 0; m = 0; f = 0; oe = -1; r = 0;
        bz = 0; vl = 0; dl = 0; ln = 0; ov = 0;
        for (int e = 1; e < n; e++) begin
            if (!in_rstn[e]) begin
                st = 0; bz = 0; vl = 0; dl = 0; ln = 0; ov = 0; r = e;
            end else if (st == 0) begin
                if (in_start[e]) begin
                    st = 1; bz = 1; vl = 0; ov = 0; s = e;
                    m = -1;
                    for (int j = s; j < NMAX + 2 && m < 0; j++) begin
                        if (ps_at(j, r, sy) == 1 && ps_at(j - 1, r, sy) == 0) m = j;
                    end
                    if (m < 0) begin
                        m = 1 << 20;
                        f = m + 1;
                    end else begin
                        f = m + 1;
                        while (f < NMAX + 2 && ps_at(f, r, sy) == 1) f++;
                    end
                    a = s + 1 + mx;
                    b = m + 1 + mx;
                    oe = (a <= m) ? a : ((b <= f) ? b : -1);
                end
            end else begin
                if (e == m + 1) dl = sat(m - s, mx);
                if (e == oe) ov = 1;
                if (e == f + 1) begin
                    ln = sat(f - m, mx); vl = 1; bz = 0; st = 0;
                end
            end
            ex_busy[k][e] = bz;
            ex_valid[k][e] = vl;
            ex_dly[k][e] = dl;
            ex_len[k][e] = ln;
            ex_ovf[k][e] = ov;
        end
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NMAX; i++) begin
            in_rstn[i] = 1'b1;
            in_start[i] = 1'b0;
            in_pin[i] = 1'b0;
        end
        in_rstn[1] = 1'b0;
        in_rstn[2] = 1'b0;
    endtask

    task automatic pulse(input int first, input int n);
        for (int i = first; i < first + n && i < NMAX; i++) in_pin[i] = 1'b1;
    endtask

    task automatic run(input string name, input int n);
        compute(0, (1 << W0) - 1, S0, n);
        compute(1, (1 << W1) - 1, S1, n);
        for (int e = 1; e < n; e++) begin
            rstn = in_rstn[e];
            start = in_start[e];
            pin = in_pin[e];
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("%s u0 busy@%0d", name, e), int'(busy0), ex_busy[0][e]);
            chk($sformatf("%s u0 valid@%0d", name, e), int'(valid0), ex_valid[0][e]);
            chk($sformatf("%s u0 dly@%0d", name, e), int'(dly0), ex_dly[0][e]);
            chk($sformatf("%s u0 len@%0d", name, e), int'(len0), ex_len[0][e]);
            chk($sformatf("%s u0 ovf@%0d", name, e), int'(ovf0), ex_ovf[0][e]);
            chk($sformatf("%s u1 busy@%0d", name, e), int'(busy1), ex_busy[1][e]);
            chk($sformatf("%s u1 valid@%0d", name, e), int'(valid1), ex_valid[1][e]);
            chk($sformatf("%s u1 dly@%0d", name, e), int'(dly1), ex_dly[1][e]);
            chk($sformatf("%s u1 len@%0d", name, e), int'(len1), ex_len[1][e]);
            chk($sformatf("%s u1 ovf@%0d", name, e), int'(ovf1), ex_ovf[1][e]);
        end
    endtask

    initial begin
        clear_stim();
        in_start[5] = 1'b1;
        pulse(9, 4);
        run("basic", 40);
        chk("basic dly", int'(dly0), 5);
        chk("basic len", int'(len0), 4);
        chk("basic valid", int'(valid0), 1);
        chk("basic ovf", int'(ovf0), 0);

        clear_stim();
        in_start[5] = 1'b1;
        pulse(7, 1);
        run("minpulse", 30);
        chk("minpulse dly", int'(dly0), 3);
        chk("minpulse len", int'(len0), 1);
        chk("minpulse valid", int'(valid0), 1);

        clear_stim();
        pulse(3, 5);
        in_start[5] = 1'b1;
        pulse(12, 2);
        run("prehigh", 40);
        chk("prehigh dly", int'(dly0), 8);
        chk("prehigh len", int'(len0), 2);

        clear_stim();
        in_start[5] = 1'b1;
        pulse(26, 3);
        in_start[45] = 1'b1;
        run("saturate", 60);
        chk("saturate u0 dly", int'(dly0), 22);
        chk("saturate u1 dly", int'(dly1), 15);
        chk("saturate u1 len", int'(len1), 3);
        chk("saturate u1 valid", int'(valid1), 0);
        chk("saturate u1 ovf", int'(ovf1), 0);
        chk("saturate u1 busy", int'(busy1), 1);

        clear_stim();
        in_start[5] = 1'b1;
        pulse(9, 20);
        in_rstn[15] = 1'b0;
        pulse(35, 3);
        run("midreset", 50);
        chk("midreset valid", int'(valid0), 0);
        chk("midreset dly", int'(dly0), 0);
        chk("midreset len", int'(len0), 0);
        chk("midreset busy", int'(busy0), 0);

        clear_stim();
        in_start[5] = 1'b1;
        pulse(7, 2);
        in_start[12] = 1'b1;
        in_start[14] = 1'b1;
        pulse(20, 3);
        run("b2b", 40);
        chk("b2b dly", int'(dly0), 9);
        chk("b2b len", int'(len0), 3);
        chk("b2b valid", int'(valid0), 1);

        for (int sc = 0; sc < 8; sc++) begin
            int i;
            clear_stim();
            i = 3;
            while (i < 400) begin
                int rl;
                bit v;
                rl = $urandom_range(1, 40);
                v = 1'($urandom_range(0, 1));
                for (int j = 0; j < rl && i < 400; j++) begin
                    in_pin[i] = v;
                    i++;
                end
            end
            for (int e = 3; e < 400; e++) begin
                in_start[e] = ($urandom_range(0, 5) == 0);
                if ($urandom_range(0, 199) == 0) in_rstn[e] = 1'b0;
            end
            run($sformatf("rand%0d", sc), 400);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
